// File: rtl/sa_pkg.sv
// rtl/sa_pkg.sv - shared sizing defaults and types for sa_2D and its result drain
//
// Contents:
//   WIDTH, HPE, VPE  default operand width and array geometry
//   RES_W, ROW_W     derived result width and one-row beat width
//   ROW_IDX_W        row index width (at least 1 bit)
//   idx_w()          index width helper for arbitrary VPE
//   drain_state_t    two-state drain FSM encoding
package sa_pkg;

  localparam int WIDTH = 16;
  localparam int HPE   = 64;
  localparam int VPE   = 64;

  localparam int RES_W = 2 * WIDTH;
  localparam int ROW_W = RES_W * HPE;

  // $clog2(1) is 0, but a row index port still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ROW_IDX_W = idx_w(VPE);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } drain_state_t;

endpackage

// File: rtl/sa_row_mux.sv
// rtl/sa_row_mux.sv - combinational row selector from the result snapshot
//
// Ports:
//   snap  in   N_BEATS*BEAT_W  frozen accumulator snapshot, row 0 at the MSB end
//   row   in   IDX_W           row index to present
//   data  out  BEAT_W          selected row, column 0 in the MSBs
module sa_row_mux
  import sa_pkg::*;
#(
  parameter int BEAT_W  = sa_pkg::ROW_W,
  parameter int N_BEATS = sa_pkg::VPE,
  parameter int IDX_W   = idx_w(N_BEATS)
) (
  input  logic [N_BEATS*BEAT_W-1:0] snap,
  input  logic [IDX_W-1:0]          row,
  output logic [BEAT_W-1:0]         data
);

  // Row r is the r-th BEAT_W slice counted down from the MSB. Indices past
  // N_BEATS-1 never occur because the drain counter stops at the last row.
  always_comb begin
    data = '0;
    for (int r = 0; r < N_BEATS; r++) begin
      if (row == IDX_W'(r)) begin
        data = snap[(N_BEATS - r) * BEAT_W - 1 -: BEAT_W];
      end
    end
  end

endmodule

// File: rtl/sa_result_drain.sv
// rtl/sa_result_drain.sv - snapshot the sa_2D accumulator bus and stream it out row by row
//
// Ports:
//   CLK        in   single clock, rising edge
//   RST        in   asynchronous active-high reset
//   Y          in   flat accumulator bus, PE (0,0) at the MSB end
//   START      in   one-cycle capture request, honoured only when idle
//   OUT_DATA   out  one row of results, column 0 in the MSBs
//   OUT_ROW    out  row index of the current beat
//   OUT_VALID  out  beat available
//   OUT_READY  in   downstream accepts the beat
//   BUSY       out  a drain is in progress
//   DONE       out  one-cycle pulse after the last beat transfers
//   OVERRUN    out  sticky, START seen while a drain was in progress
module sa_result_drain #(
  parameter int WIDTH = sa_pkg::WIDTH,
  parameter int HPE   = sa_pkg::HPE,
  parameter int VPE   = sa_pkg::VPE,
  localparam int ROW_IDX_W = sa_pkg::idx_w(VPE)
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [2*WIDTH*HPE*VPE-1:0]  Y,
  input  logic                        START,
  output logic [2*WIDTH*HPE-1:0]      OUT_DATA,
  output logic [ROW_IDX_W-1:0]        OUT_ROW,
  output logic                        OUT_VALID,
  input  logic                        OUT_READY,
  output logic                        BUSY,
  output logic                        DONE,
  output logic                        OVERRUN
);

  import sa_pkg::*;

  localparam int BEAT_W = 2 * WIDTH * HPE;
  localparam int SNAP_W = BEAT_W * VPE;
  localparam logic [ROW_IDX_W-1:0] LAST_ROW = ROW_IDX_W'(VPE - 1);

  drain_state_t        state;
  logic [SNAP_W-1:0]   snap;

  // OUT_VALID and BUSY are registered copies of "state == SEND", so
  // OUT_READY only ever reaches flop D inputs, never an output directly.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      snap      <= '0;
      OUT_ROW   <= '0;
      OUT_VALID <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            snap      <= Y;
            OUT_ROW   <= '0;
            OUT_VALID <= 1'b1;
            BUSY      <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          // Includes a START coinciding with the final transfer: the block
          // is still busy on that edge, so the request is dropped.
          if (START) begin
            OVERRUN <= 1'b1;
          end
          if (OUT_READY) begin
            if (OUT_ROW == LAST_ROW) begin
              OUT_VALID <= 1'b0;
              BUSY      <= 1'b0;
              DONE      <= 1'b1;
              state     <= IDLE;
            end else begin
              OUT_ROW <= OUT_ROW + ROW_IDX_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // OUT_DATA is a pure function of registered state, so it holds during
  // stalls and is zero out of reset (snapshot cleared, row 0 selected).
  sa_row_mux #(
    .BEAT_W  (BEAT_W),
    .N_BEATS (VPE),
    .IDX_W   (ROW_IDX_W)
  ) u_row_mux (
    .snap (snap),
    .row  (OUT_ROW),
    .data (OUT_DATA)
  );

endmodule

// File: tb/tb_sa_result_drain.sv
// tb/tb_sa_result_drain.sv - self-checking bench for sa_result_drain
module tb_sa_result_drain;

  localparam int SH = 3, SV = 3;
  localparam int S_RW = 8, S_BW = S_RW * SH, S_YW = S_BW * SV;
  localparam int BH = 64, BV = 64;
  localparam int B_RW = 32, B_BW = B_RW * BH, B_YW = B_BW * BV;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  logic [S_YW-1:0] s_y;
  logic            s_start, s_ready;
  logic [S_BW-1:0] s_data;
  logic [1:0]      s_row;
  logic            s_valid, s_busy, s_done, s_overrun;

  logic [B_YW-1:0] b_y;
  logic            b_start, b_ready;
  logic [B_BW-1:0] b_data;
  logic [5:0]      b_row;
  logic            b_valid, b_busy, b_done, b_overrun;

  sa_result_drain #(.WIDTH(4), .HPE(SH), .VPE(SV)) u_small (
    .CLK(CLK), .RST(RST), .Y(s_y), .START(s_start),
    .OUT_DATA(s_data), .OUT_ROW(s_row), .OUT_VALID(s_valid), .OUT_READY(s_ready),
    .BUSY(s_busy), .DONE(s_done), .OVERRUN(s_overrun)
  );

  sa_result_drain u_big (
    .CLK(CLK), .RST(RST), .Y(b_y), .START(b_start),
    .OUT_DATA(b_data), .OUT_ROW(b_row), .OUT_VALID(b_valid), .OUT_READY(b_ready),
    .BUSY(b_busy), .DONE(b_done), .OVERRUN(b_overrun)
  );

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;

  // reference model: the PE result grid, row-major, (0,0) first
  logic [S_RW-1:0] s_pe [SV][SH];
  logic [B_RW-1:0] b_pe [BV][BH];

  function automatic logic [S_YW-1:0] s_pack();
    logic [S_YW-1:0] y;
    y = '0;
    for (int r = 0; r < SV; r++)
      for (int c = 0; c < SH; c++)
        y = (y << S_RW) | S_YW'(s_pe[r][c]);
    return y;
  endfunction

  function automatic logic [S_BW-1:0] s_row_exp(input int r);
    logic [S_BW-1:0] v;
    v = '0;
    for (int c = 0; c < SH; c++) v = (v << S_RW) | S_BW'(s_pe[r][c]);
    return v;
  endfunction

  function automatic logic [B_YW-1:0] b_pack();
    logic [B_YW-1:0] y;
    y = '0;
    for (int r = 0; r < BV; r++)
      for (int c = 0; c < BH; c++)
        y = (y << B_RW) | B_YW'(b_pe[r][c]);
    return y;
  endfunction

  function automatic logic [B_BW-1:0] b_row_exp(input int r);
    logic [B_BW-1:0] v;
    v = '0;
    for (int c = 0; c < BH; c++) v = (v << B_RW) | B_BW'(b_pe[r][c]);
    return v;
  endfunction

  task automatic s_randomize();
    for (int r = 0; r < SV; r++)
      for (int c = 0; c < SH; c++)
        s_pe[r][c] = S_RW'($urandom_range(1, 255));
    s_y = s_pack();
  endtask

  // monitors: record transfers and DONE pulses, sampled mid-cycle
  logic [S_BW-1:0] s_beats[$];
  int              s_rows[$];
  int              s_bcyc[$];
  int              s_dcyc[$];
  logic            s_busy_at_done[$];
  logic [B_BW-1:0] b_beats[$];
  int              b_rows[$];
  int              b_dcyc[$];

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (s_valid === 1'b1 && s_ready === 1'b1) begin
      s_beats.push_back(s_data);
      s_rows.push_back(int'(s_row));
      s_bcyc.push_back(cyc);
    end
    if (s_done === 1'b1) begin
      s_dcyc.push_back(cyc);
      s_busy_at_done.push_back(s_busy);
    end
    if (b_valid === 1'b1 && b_ready === 1'b1) begin
      b_beats.push_back(b_data);
      b_rows.push_back(int'(b_row));
    end
    if (b_done === 1'b1) b_dcyc.push_back(cyc);
  end

  task automatic clear_mon();
    s_beats.delete(); s_rows.delete(); s_bcyc.delete();
    s_dcyc.delete(); s_busy_at_done.delete();
    b_beats.delete(); b_rows.delete(); b_dcyc.delete();
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_s();
    s_start = 1'b1;
    step();
    s_start = 1'b0;
  endtask

  task automatic apply_reset();
    #2 RST = 1'b1;
    step();
    step();
    RST = 1'b0;
    step();
  endtask

  // compares the three recorded small beats against the model
  task automatic check_small_beats(input string tag, input int base, input int first_cyc);
    for (int i = 0; i < SV; i++) begin
      if (base + i < s_beats.size()) begin
        n_checks++;
        if (s_beats[base+i] !== s_row_exp(i))
          $display("FAIL %s_data[%0d]: got %h want %h", tag, i, s_beats[base+i], s_row_exp(i));
        else n_pass++;
        n_checks++;
        if (s_rows[base+i] !== i)
          $display("FAIL %s_row[%0d]: got %0d want %0d", tag, i, s_rows[base+i], i);
        else n_pass++;
        if (first_cyc >= 0) begin
          n_checks++;
          if (s_bcyc[base+i] !== first_cyc + i)
            $display("FAIL %s_beat_cycle[%0d]: got %0d want %0d", tag, i, s_bcyc[base+i], first_cyc + i);
          else n_pass++;
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [S_BW-1:0] zero_s;
    logic [B_BW-1:0] zero_b;
    zero_s = '0;
    zero_b = '0;
    s_randomize();
    for (int r = 0; r < BV; r++)
      for (int c = 0; c < BH; c++) b_pe[r][c] = B_RW'($urandom_range(1, 1000));
    b_y = b_pack();
    s_ready = 1'b0;
    b_ready = 1'b0;
    s_start = 1'b1; b_start = 1'b1;
    step();
    step();
    s_start = 1'b0; b_start = 1'b0;
    n_checks++;
    if (s_overrun !== 1'b1) $display("FAIL pre_reset_overrun: got %b want 1", s_overrun);
    else n_pass++;
    #3 RST = 1'b1;
    #1;
    n_checks++;
    if ({s_valid, s_busy, s_done, s_overrun, s_row} !== 6'b0)
      $display("FAIL reset_ctrl: got %b want 000000", {s_valid, s_busy, s_done, s_overrun, s_row});
    else n_pass++;
    n_checks++;
    if (s_data !== zero_s) $display("FAIL reset_data: got %h want 0", s_data);
    else n_pass++;
    n_checks++;
    if ({b_valid, b_busy, b_done, b_overrun, b_row} !== 10'b0 || b_data !== zero_b)
      $display("FAIL reset_big: got ctrl %b want 0", {b_valid, b_busy, b_done, b_overrun, b_row});
    else n_pass++;
    step();
    RST = 1'b0;
    s_ready = 1'b1;
    b_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (s_valid !== 1'b0 || s_busy !== 1'b0)
        $display("FAIL idle_after_reset[%0d]: got valid %b busy %b want 0 0", i, s_valid, s_busy);
      else n_pass++;
    end
  endtask

  task automatic test_basic();
    int k;
    logic [S_BW-1:0] row0_const;
    row0_const = 24'h010203;
    for (int r = 0; r < SV; r++)
      for (int c = 0; c < SH; c++) s_pe[r][c] = S_RW'(r * 3 + c + 1);
    s_y = s_pack();
    s_ready = 1'b1;
    clear_mon();
    k = cyc;
    pulse_s();
    n_checks++;
    if (s_valid !== 1'b1 || s_busy !== 1'b1 || s_row !== 2'd0)
      $display("FAIL basic_first_beat: got valid %b busy %b row %0d want 1 1 0", s_valid, s_busy, s_row);
    else n_pass++;
    repeat (6) step();
    n_checks++;
    if (s_beats.size() !== 3) $display("FAIL basic_count: got %0d want 3", s_beats.size());
    else n_pass++;
    if (s_beats.size() > 0) begin
      n_checks++;
      if (s_beats[0] !== row0_const) $display("FAIL basic_row0_const: got %h want %h", s_beats[0], row0_const);
      else n_pass++;
    end
    check_small_beats("basic", 0, k + 1);
    n_checks++;
    if (s_dcyc.size() !== 1 || s_dcyc[0] !== k + 4)
      $display("FAIL basic_done_cycle: got %0d pulses first %0d want 1 at %0d", s_dcyc.size(), (s_dcyc.size() > 0) ? s_dcyc[0] : -1, k + 4);
    else n_pass++;
    n_checks++;
    if (s_busy_at_done.size() !== 1 || s_busy_at_done[0] !== 1'b0)
      $display("FAIL basic_busy_at_done: got %0d samples want one 0", s_busy_at_done.size());
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int k;
    s_randomize();
    s_ready = 1'b1;
    clear_mon();
    k = cyc;
    pulse_s();
    step();
    s_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (s_valid !== 1'b1 || s_row !== 2'd1 || s_data !== s_row_exp(1))
        $display("FAIL stall_hold[%0d]: got valid %b row %0d data %h want 1 1 %h", i, s_valid, s_row, s_data, s_row_exp(1));
      else n_pass++;
      step();
    end
    s_ready = 1'b1;
    repeat (5) step();
    n_checks++;
    if (s_beats.size() !== 3) $display("FAIL bp_count: got %0d want 3", s_beats.size());
    else n_pass++;
    check_small_beats("bp", 0, -1);
    n_checks++;
    if (s_dcyc.size() !== 1 || s_dcyc[0] !== k + 6)
      $display("FAIL bp_done_cycle: got %0d pulses first %0d want 1 at %0d", s_dcyc.size(), (s_dcyc.size() > 0) ? s_dcyc[0] : -1, k + 6);
    else n_pass++;
  endtask

  task automatic test_isolation();
    s_randomize();
    s_ready = 1'b1;
    clear_mon();
    pulse_s();
    s_y = '1;
    repeat (6) step();
    n_checks++;
    if (s_beats.size() !== 3) $display("FAIL iso_count: got %0d want 3", s_beats.size());
    else n_pass++;
    check_small_beats("iso", 0, -1);
    s_y = s_pack();
  endtask

  task automatic test_back_to_back();
    int found;
    logic [S_BW-1:0] first_exp[SV];
    s_randomize();
    for (int i = 0; i < SV; i++) first_exp[i] = s_row_exp(i);
    s_ready = 1'b1;
    clear_mon();
    pulse_s();
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      step();
      if (s_done === 1'b1) found = 1;
    end
    n_checks++;
    if (found == 0) $display("FAIL b2b_done_timeout: got no DONE want DONE within 10 cycles");
    else n_pass++;
    s_randomize();
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    n_checks++;
    if (s_valid !== 1'b1 || s_busy !== 1'b1 || s_row !== 2'd0 || s_data !== s_row_exp(0))
      $display("FAIL b2b_restart: got valid %b busy %b row %0d data %h want 1 1 0 %h", s_valid, s_busy, s_row, s_data, s_row_exp(0));
    else n_pass++;
    repeat (5) step();
    n_checks++;
    if (s_beats.size() !== 6) $display("FAIL b2b_count: got %0d want 6", s_beats.size());
    else n_pass++;
    for (int i = 0; i < SV; i++) begin
      if (i < s_beats.size()) begin
        n_checks++;
        if (s_beats[i] !== first_exp[i]) $display("FAIL b2b_first[%0d]: got %h want %h", i, s_beats[i], first_exp[i]);
        else n_pass++;
      end
    end
    check_small_beats("b2b_second", 3, -1);
    n_checks++;
    if (s_overrun !== 1'b0) $display("FAIL b2b_no_overrun: got %b want 0", s_overrun);
    else n_pass++;
  endtask

  task automatic test_overrun();
    int k;
    apply_reset();
    s_randomize();
    s_ready = 1'b1;
    clear_mon();
    k = cyc;
    pulse_s();
    step();
    s_y = ~s_y;
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    n_checks++;
    if (s_overrun !== 1'b1) $display("FAIL overrun_set: got %b want 1", s_overrun);
    else n_pass++;
    repeat (5) step();
    n_checks++;
    if (s_beats.size() !== 3) $display("FAIL overrun_count: got %0d want 3", s_beats.size());
    else n_pass++;
    check_small_beats("overrun", 0, k + 1);
    n_checks++;
    if (s_dcyc.size() !== 1 || s_dcyc[0] !== k + 4 || s_overrun !== 1'b1 || s_valid !== 1'b0)
      $display("FAIL overrun_after: got dones %0d overrun %b valid %b want 1 1 0", s_dcyc.size(), s_overrun, s_valid);
    else n_pass++;

    apply_reset();
    s_randomize();
    clear_mon();
    pulse_s();
    step();
    step();
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    n_checks++;
    if (s_done !== 1'b1 || s_overrun !== 1'b1 || s_valid !== 1'b0)
      $display("FAIL overrun_final_edge: got done %b overrun %b valid %b want 1 1 0", s_done, s_overrun, s_valid);
    else n_pass++;
    step();
    n_checks++;
    if (s_valid !== 1'b0 || s_busy !== 1'b0)
      $display("FAIL overrun_final_ignored: got valid %b busy %b want 0 0", s_valid, s_busy);
    else n_pass++;
  endtask

  task automatic test_abort();
    apply_reset();
    s_randomize();
    s_ready = 1'b1;
    clear_mon();
    pulse_s();
    step();
    #2 RST = 1'b1;
    #1;
    n_checks++;
    if (s_valid !== 1'b0 || s_row !== 2'd0 || s_busy !== 1'b0)
      $display("FAIL abort_immediate: got valid %b row %0d busy %b want 0 0 0", s_valid, s_row, s_busy);
    else n_pass++;
    step();
    step();
    RST = 1'b0;
    repeat (6) step();
    n_checks++;
    if (s_beats.size() !== 1 || s_dcyc.size() !== 0)
      $display("FAIL abort_quiet: got beats %0d dones %0d want 1 0", s_beats.size(), s_dcyc.size());
    else n_pass++;
    clear_mon();
    pulse_s();
    repeat (6) step();
    n_checks++;
    if (s_beats.size() !== 3 || s_dcyc.size() !== 1)
      $display("FAIL abort_redrain: got beats %0d dones %0d want 3 1", s_beats.size(), s_dcyc.size());
    else n_pass++;
    check_small_beats("abort_redrain", 0, -1);
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      s_randomize();
      clear_mon();
      s_ready = 1'($urandom_range(0, 1));
      pulse_s();
      for (int c = 0; c < 40 && s_dcyc.size() == 0; c++) begin
        s_ready = (c >= 30) ? 1'b1 : 1'($urandom_range(0, 1));
        step();
      end
      s_ready = 1'b1;
      step();
      n_checks++;
      if (s_beats.size() !== 3 || s_dcyc.size() !== 1)
        $display("FAIL rand%0d_count: got beats %0d dones %0d want 3 1", it, s_beats.size(), s_dcyc.size());
      else n_pass++;
      check_small_beats($sformatf("rand%0d", it), 0, -1);
      if (s_beats.size() == 3 && s_dcyc.size() == 1) begin
        n_checks++;
        if (s_dcyc[0] !== s_bcyc[2] + 1)
          $display("FAIL rand%0d_done_cycle: got %0d want %0d", it, s_dcyc[0], s_bcyc[2] + 1);
        else n_pass++;
      end
    end
  endtask

  task automatic test_default_size();
    int k;
    int bad_data;
    int bad_row;
    for (int r = 0; r < BV; r++)
      for (int c = 0; c < BH; c++) b_pe[r][c] = B_RW'($urandom);
    b_y = b_pack();
    b_ready = 1'b1;
    clear_mon();
    k = cyc;
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    repeat (BV + 4) step();
    n_checks++;
    if (b_beats.size() !== BV) $display("FAIL big_count: got %0d want %0d", b_beats.size(), BV);
    else n_pass++;
    bad_data = 0;
    bad_row = 0;
    for (int r = 0; r < BV && r < b_beats.size(); r++) begin
      if (b_beats[r] !== b_row_exp(r)) begin
        if (bad_data == 0)
          $display("FAIL big_data row %0d: got low word %h want %h", r, b_beats[r][31:0], b_row_exp(r) >> 0);
        bad_data++;
      end
      if (b_rows[r] !== r) bad_row++;
    end
    n_checks++;
    if (bad_data != 0) $display("FAIL big_data_rows: got %0d bad rows want 0", bad_data);
    else n_pass++;
    n_checks++;
    if (bad_row != 0) $display("FAIL big_row_index: got %0d bad indices want 0", bad_row);
    else n_pass++;
    n_checks++;
    if (b_dcyc.size() !== 1 || b_dcyc[0] !== k + BV + 1)
      $display("FAIL big_done_cycle: got %0d pulses first %0d want 1 at %0d", b_dcyc.size(), (b_dcyc.size() > 0) ? b_dcyc[0] : -1, k + BV + 1);
    else n_pass++;
  endtask

  initial begin
    s_y = '0; s_start = 1'b0; s_ready = 1'b1;
    b_y = '0; b_start = 1'b0; b_ready = 1'b1;
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    step();
    test_reset();
    test_basic();
    test_backpressure();
    test_isolation();
    test_back_to_back();
    test_overrun();
    test_abort();
    test_random();
    test_default_size();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sa_result_drain.md
# sa_result_drain

Output-side companion to `sa_2D`. The array presents every PE accumulator at once on a flat bus. This block snapshots that bus on command and streams it out one row per beat over a valid/ready handshake, for a downstream writer or scoreboard. It sits directly on `sa_2D`'s `Y` port and is the drain counterpart of the skewed operand feeder on the `AA`/`BB` side.

## Interface
- `WIDTH`, 16, operand width; each result is `2*WIDTH` bits.
- `HPE`, 64, PEs per row, which is also results per output beat.
- `VPE`, 64, number of rows, which is also beats per drain.
- `CLK`  in  1  single clock; all state on rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `Y`  in  `2*WIDTH*HPE*VPE`  flat accumulator bus from `sa_2D`.
- `START`  in  1  one-cycle capture request.
- `OUT_DATA`  out  `2*WIDTH*HPE`  one row of results.
- `OUT_ROW`  out  `$clog2(VPE)` (min 1)  row index of the current beat.
- `OUT_VALID`  out  1  beat available.
- `OUT_READY`  in  1  downstream accepts the beat.
- `BUSY`  out  1  a drain is in progress.
- `DONE`  out  1  one-cycle pulse after the last beat.
- `OVERRUN`  out  1  sticky; a `START` arrived while busy.

## Operation
- **Reset values:** state IDLE; `OUT_VALID`, `BUSY`, `DONE` and `OVERRUN` all 0; `OUT_ROW` 0; `OUT_DATA` 0; snapshot register 0.
- **Result ordering on `Y`:** PE (r,c) occupies bits `((HPE*VPE-(r*HPE+c))*2W-1)` down to `((HPE*VPE-(r*HPE+c+1))*2W)`. PE (0,0) sits at the MSB end.
- **Beat packing:** the beat for row r is the contiguous slice of the snapshot at bits `((HPE*VPE-r*HPE)*2W-1)` down to `((HPE*VPE-(r+1)*HPE)*2W)`. Column 0 lands in the MSBs of `OUT_DATA`. No arithmetic is applied; data passes bit-exact.
- **IDLE state:**
  - `START`=1 loads the full `Y` into the snapshot at that edge.
  - `OUT_ROW` is set to 0 and the state moves to SEND.
- **SEND state:**
  - `OUT_VALID`=1 and `BUSY`=1.
  - A beat transfers on an edge where `OUT_VALID` & `OUT_READY` are both 1.
  - If the transferred row is below `VPE-1`, `OUT_ROW` increments.
  - If the transferred row is `VPE-1`, the state returns to IDLE and `DONE`=1 for the following cycle.
- **Stalls:** while `OUT_VALID`=1 and `OUT_READY`=0, `OUT_DATA` and `OUT_ROW` hold stable.
- **Isolation from `Y`:** the snapshot is frozen until the next accepted `START`. Changes on `Y` during SEND never affect output.
- **START while busy:** `START` in SEND is ignored and sets `OVERRUN`. This includes `START` on the same edge as the final beat transfer. `OVERRUN` clears only on `RST`.
- **Back-to-back drains:** `START` in the `DONE` cycle (state IDLE) is accepted normally.
- **Reset mid-drain:** asynchronous `RST` aborts immediately. All outputs return to reset values and no `DONE` is issued.

## Timing
- Capture: `START` high at edge t starts the drain; `OUT_VALID`=1 from t+1 with row 0.
- With `OUT_READY` held at 1, beats transfer on edges t+1 … t+VPE.
- `DONE` is high in cycle t+VPE+1, and `BUSY`=0 in that same cycle.
- Minimum drain is `VPE+1` cycles from `START` to `DONE`; stalls add one cycle each.
- No combinational path from `OUT_READY` to `OUT_VALID` or `OUT_DATA`.

## Structure
- Shared package `sa_pkg`:
  - `WIDTH`, `HPE`, `VPE` defaults, used by both `sa_2D` and this block.
  - Derived `RES_W = 2*WIDTH`, `ROW_W = RES_W*HPE`, `ROW_IDX_W`.
  - Two-state enum {IDLE, SEND}.
- Sub-module `sa_row_mux`: a purely combinational selector from the snapshot and `OUT_ROW` to `OUT_DATA`. The FSM, counter and snapshot register stay in the top level.
- The bench uses small parameters for readability (`WIDTH`=4, `HPE`=`VPE`=3) plus one default-size run.

## Test plan
- **Reset:** assert `RST` asynchronously mid-cycle. All outputs go to 0 immediately; `OUT_VALID` stays 0 for 5 cycles after release with no `START`.
- **Basic drain:** small params, PE(r,c) = r*3+c+1. Pulse `START` with `OUT_READY`=1. Expect 3 consecutive beats: row 0 = {1,2,3}, row 1 = {4,5,6}, row 2 = {7,8,9}, each listed MSB-first. `DONE` is in the 4th cycle after `START`.
- **Backpressure:** drop `OUT_READY` for 2 cycles during row 1. Row 1 data and `OUT_ROW`=1 hold; `DONE` arrives 2 cycles later than in the basic drain.
- **Snapshot isolation:** change `Y` to all 0xFF in the cycle after `START`. All streamed beats still carry the original values.
- **Overrun and restart:**
  - `START` during row 1: `OVERRUN`=1 and stays 1; the current drain completes unchanged.
  - `START` in the `DONE` cycle: a new drain begins the next cycle.
- **Abort:** assert `RST` after row 0 transfers. No further beats and no `DONE`. After release, `START` drains from row 0 again.
